// File: rtl/freelist.sv
// freelist: rename-stage physical tag free list, 4 allocs + 4 frees per cycle, one head checkpoint.
// Define FREELIST_CHECK_EN to build the sticky o_err overflow/underflow checker.
module freelist #(
    parameter int WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_alloc_en,
    input  logic [3:0]           i_req_mask,
    output logic [4*WIDTH-1:0]   o_tags4x,
    output logic                 o_ready,
    input  logic [3:0]           i_free_mask,
    input  logic [4*WIDTH-1:0]   i_free_tags4x,
    input  logic                 i_save,
    input  logic                 i_return,
    output logic                 o_busy,
    output logic [WIDTH:0]       o_count,
    output logic                 o_err
);
    localparam int SIZE = 1 << WIDTH;
    localparam int PW = WIDTH + 1;
    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH:0]   head_q, head_d, tail_q, tail_d, save_q, save_d, count, head_alloc;
    logic             busy_q, busy_d, alloc;
    logic [2:0]       req_n, free_n;
    logic [2:0]       req_off [4];
    logic [2:0]       free_off [4];
    logic [3:0]       free_v;

    assign count = tail_q - head_q;
    assign o_count = count;
    assign o_busy = busy_q;

    // Prefix counts give each slot its compacted offset from head/tail.
    always_comb begin
        req_n = '0;
        free_n = '0;
        free_v = '0;
        for (int j = 0; j < 4; j++) begin
            req_off[j] = req_n;
            free_off[j] = free_n;
            free_v[j] = i_free_mask[j] && (i_free_tags4x[j*WIDTH +: WIDTH] != '0);
            req_n = req_n + {2'b0, i_req_mask[j]};
            free_n = free_n + {2'b0, free_v[j]};
        end
    end

    assign o_ready = (count >= PW'(req_n)) && !i_return;
    assign alloc = i_alloc_en && o_ready;
    assign head_alloc = head_q + (alloc ? PW'(req_n) : '0);

    always_comb begin
        o_tags4x = '0;
        for (int j = 0; j < 4; j++)
            o_tags4x[j*WIDTH +: WIDTH] = (o_ready && i_req_mask[j]) ?
                mem_q[head_q[WIDTH-1:0] + WIDTH'(req_off[j])] : '0;
    end

    always_comb begin
        head_d = i_return ? save_q : head_alloc;
        save_d = i_return ? save_q : i_save ? head_alloc : save_q;
        busy_d = i_return ? 1'b0 : i_save ? 1'b1 : busy_q;
        tail_d = tail_q + PW'(free_n);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < SIZE; k++)
                mem_q[k] <= (k < SIZE - 1) ? WIDTH'(k + 1) : '0;
            head_q <= '0;
            tail_q <= PW'(SIZE - 1);
            save_q <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int j = 0; j < 4; j++)
                if (free_v[j])
                    mem_q[tail_q[WIDTH-1:0] + WIDTH'(free_off[j])] <= i_free_tags4x[j*WIDTH +: WIDTH];
            head_q <= head_d;
            tail_q <= tail_d;
            save_q <= save_d;
            busy_q <= busy_d;
        end
    end

`ifdef FREELIST_CHECK_EN
    localparam int CW = WIDTH + 2;
    logic          err_q, err_d;
    logic [CW-1:0] count_nxt;

    assign count_nxt = {1'b0, count} + CW'(free_n) - CW'(alloc ? req_n : 3'd0);
    assign err_d = err_q || (i_alloc_en && !o_ready && (i_req_mask != '0)) || (count_nxt > CW'(SIZE - 1));
    assign o_err = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_freelist.sv
// tb_freelist: randomized and directed checks of freelist against a circular-list model with unbounded indices.
module tb_freelist;
    localparam int W = 5;
    logic          clk, rst, alloc_en, save, ret;
    logic [3:0]    req_mask, free_mask;
    logic [4*W-1:0] tags, free_tags;
    logic          ready, busy, err;
    logic [W:0]    count;

    freelist #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_alloc_en(alloc_en), .i_req_mask(req_mask),
        .o_tags4x(tags), .o_ready(ready), .i_free_mask(free_mask), .i_free_tags4x(free_tags),
        .i_save(save), .i_return(ret), .o_busy(busy), .o_count(count), .o_err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int mm [32];
    int h, t, sh;
    bit m_busy, m_err, m_alloc;
    int m_tags [4];
    int obs_tags;
    bit obs_ready;
    int out_tag [$];
    int out_idx [$];

    task automatic check(input string tg, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tg, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1; alloc_en = 0; req_mask = 0; free_mask = 0; free_tags = 0; save = 0; ret = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 32; k++) mm[k] = (k < 31) ? k + 1 : 0;
        h = 0; t = 31; sh = 0; m_busy = 0; m_err = 0;
        out_tag.delete(); out_idx.delete();
    endtask

    task automatic step(input bit en, input bit [3:0] rq, input bit [3:0] fm, input bit [19:0] ft,
                        input bit sv, input bit rt);
        int n, nf, off, cnt, hn;
        bit rdy;
        bit [19:0] et;
        alloc_en = en; req_mask = rq; free_mask = fm; free_tags = ft; save = sv; ret = rt;
        #2;
        cnt = t - h;
        n = $countones(rq);
        rdy = (cnt >= n) && !rt;
        et = '0; off = 0;
        for (int j = 0; j < 4; j++) begin
            m_tags[j] = 0;
            if (rq[j]) begin
                if (rdy) begin
                    m_tags[j] = mm[(h + off) % 32];
                    et[j*5 +: 5] = 5'(m_tags[j]);
                end
                off++;
            end
        end
        obs_tags = int'(tags);
        obs_ready = ready;
        check("count", int'(count), cnt);
        check("ready", int'(ready), int'(rdy));
        check("tags", int'(tags), int'(et));
        check("busy", int'(busy), int'(m_busy));
        check("err", int'(err), int'(m_err));
        m_alloc = en && rdy;
        hn = h + (m_alloc ? n : 0);
        nf = 0;
        for (int j = 0; j < 4; j++)
            if (fm[j] && ft[j*5 +: 5] != 0) begin
                mm[t % 32] = int'(ft[j*5 +: 5]);
                t++;
                nf++;
            end
`ifdef FREELIST_CHECK_EN
        if ((en && !rdy && rq != 0) || (cnt + nf - (m_alloc ? n : 0) > 31)) m_err = 1;
`endif
        if (rt) begin
            h = sh; m_busy = 0;
        end else begin
            h = hn;
            if (sv) begin sh = hn; m_busy = 1; end
        end
        @(posedge clk); #1;
    endtask

    bit en_r, sv_r, rt_r;
    bit [3:0] rq_r, fm_r;
    bit [19:0] ft_r;
    int cut, h0, off_r, p;

    initial begin
        do_reset();
        check("rst_count", int'(count), 31);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        step(1, 4'b1011, 0, 0, 0, 0);
        check("tags_1011", obs_tags, int'({5'd3, 5'd0, 5'd2, 5'd1}));
        check("count_28", int'(count), 28);

        do_reset();
        repeat (7) step(1, 4'b1111, 0, 0, 0, 0);
        step(1, 4'b1111, 0, 0, 0, 0);
        check("full_req_blocked", int'(obs_ready), 0);
        step(1, 4'b0111, 0, 0, 0, 0);
        check("last3_ready", int'(obs_ready), 1);
        check("last3_tags", obs_tags, int'({5'd0, 5'd31, 5'd30, 5'd29}));
        check("empty_count", int'(count), 0);
        step(1, 4'b0001, 4'b0101, {5'd0, 5'd9, 5'd0, 5'd5}, 0, 0);
        check("no_bypass", int'(obs_ready), 0);
        step(1, 4'b0011, 0, 0, 0, 0);
        check("freed_tags", obs_tags, int'({5'd0, 5'd0, 5'd9, 5'd5}));

        do_reset();
        step(1, 4'b0001, 0, 0, 1, 0);
        check("save_tag", obs_tags, 1);
        check("busy_set", int'(busy), 1);
        step(1, 4'b1111, 0, 0, 0, 0);
        step(1, 4'b1111, 0, 0, 0, 0);
        step(0, 0, 4'b0001, {15'd0, 5'd20}, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("ret_busy", int'(busy), 0);
        check("ret_count", int'(count), 31);
        step(1, 4'b0001, 0, 0, 0, 0);
        check("ret_tag", obs_tags, 2);
        step(1, 4'b0011, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 0, 1, 1);
        check("sr_ready", int'(obs_ready), 0);
        check("sr_tags", obs_tags, 0);
        check("sr_busy", int'(busy), 0);
        step(1, 4'b0001, 0, 0, 0, 0);
        check("sr_tag", obs_tags, 2);
        step(0, 0, 0, 0, 0, 1);
        step(1, 4'b0001, 0, 0, 0, 0);
        check("ckpt_kept", obs_tags, 2);

        do_reset();
        step(0, 0, 4'b0001, {15'd0, 5'd7}, 0, 0);
`ifdef FREELIST_CHECK_EN
        check("err_set", int'(err), 1);
`else
        check("err_off", int'(err), 0);
`endif
        repeat (3) step(0, 0, 0, 0, 0, 0);
        do_reset();
        check("err_rst", int'(err), 0);

        do_reset();
        for (int c = 0; c < 600; c++) begin
            en_r = $urandom_range(0, 3) != 0;
            rq_r = 4'($urandom);
            sv_r = $urandom_range(0, 9) == 0;
            rt_r = m_busy && ($urandom_range(0, 7) == 0);
            cut = m_busy ? sh : 32'h4000_0000;
            fm_r = 0; ft_r = 0;
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 2) == 0 && out_tag.size() > 0) begin
                    p = $urandom_range(0, out_tag.size() - 1);
                    if (out_idx[p] < cut) begin
                        fm_r[j] = 1;
                        ft_r[j*5 +: 5] = 5'(out_tag[p]);
                        out_tag.delete(p);
                        out_idx.delete(p);
                    end
                end else if ($urandom_range(0, 15) == 0) fm_r[j] = 1;
            end
            h0 = h;
            step(en_r, rq_r, fm_r, ft_r, sv_r, rt_r);
            if (m_alloc) begin
                off_r = 0;
                for (int j = 0; j < 4; j++)
                    if (rq_r[j]) begin
                        out_tag.push_back(m_tags[j]);
                        out_idx.push_back(h0 + off_r);
                        off_r++;
                    end
            end
            if (rt_r)
                for (int k = out_idx.size() - 1; k >= 0; k--)
                    if (out_idx[k] >= h) begin
                        out_idx.delete(k);
                        out_tag.delete(k);
                    end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the rename stage. Supplies up to four fresh physical tags per cycle to the map table's write-data inputs and accepts up to four released tags per cycle from commit. Holds one branch checkpoint of its allocation pointer, taken and restored in lock-step with the map table's save/return, so that tags allocated on a mispredicted path are reclaimed on recovery.

## Interface
- WIDTH, 5, physical tag width; SIZE = 2^WIDTH storage entries; tag 0 is reserved for x0 and is never stored or issued
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_alloc_en  input  1  rename group valid; allocation happens when i_alloc_en && o_ready
- i_req_mask  input  4  slot j requests a destination tag
- o_tags4x  output  4*WIDTH  tag for slot j at bits [(j+1)*WIDTH-1:j*WIDTH]; 0 for unrequested slots
- o_ready  output  1  enough free tags for popcount(i_req_mask) and no restore this cycle
- i_free_mask  input  4  slot j of the commit group releases a tag
- i_free_tags4x  input  4*WIDTH  released tags, same slot packing as o_tags4x
- i_save  input  1  take checkpoint (same cycle as map table save)
- i_return  input  1  restore checkpoint (same cycle as map table return)
- o_busy  output  1  checkpoint held
- o_count  output  WIDTH+1  free tags currently stored
- o_err  output  1  sticky error flag (see Configuration)

## Operation
- Storage: circular buffer of SIZE entries, head/tail pointers of WIDTH+1 bits (MSB is wrap bit); count = tail - head, modulo 2^(WIDTH+1).
- Reset: entry k = k+1 for k = 0..SIZE-2; head = 0, tail = SIZE-1; saved head = 0; o_busy = 0; o_err = 0; o_count = SIZE-1.
- Allocation: slot j receives the entry at head + (number of set i_req_mask bits below j); on an accepted group head advances by popcount(i_req_mask). Mask 0 with i_alloc_en is accepted and changes nothing.
- o_ready = (count >= popcount(i_req_mask)) && !i_return. A partial group is never allocated.
- Free: each set i_free_mask[j] with a nonzero tag is written at tail in ascending slot order (compacted); tail advances by that number. Tag 0 frees are dropped.
- Save: saved head = head value after this cycle's allocation; o_busy <= 1. A save while busy overwrites the checkpoint (single level).
- Return: head <= saved head; o_busy <= 0; allocation suppressed that cycle; frees in the same cycle still apply to tail.
- Priority: i_rst > i_return > i_save. i_save and i_return together: return wins, save ignored.
- Return with o_busy = 0: head restored to last saved value anyway (no special case).

## Timing
- o_tags4x and o_ready combinational from head, count, i_req_mask, i_return; zero-latency to map table write data.
- head, tail, checkpoint, o_busy, o_count, o_err update on the rising edge; o_count reflects the new state one cycle after the event.
- Tags freed in cycle N become allocatable in cycle N+1; no same-cycle free-to-alloc bypass.
- Simultaneous alloc and free in one cycle both apply; count changes by freed - allocated.
- Reset asserted mid-operation returns to the reset image on the next edge regardless of other inputs.

## Configuration
- FREELIST_CHECK_EN defined: o_err sets (sticky until i_rst) when i_alloc_en is high with o_ready low and i_req_mask nonzero, or when a free would make count exceed SIZE-1.
- Not defined: o_err tied to 0, no check logic; port remains present.

## Test plan
- Reset, WIDTH=5 -> o_count = 31, o_ready = 1, o_busy = 0; alloc mask 4'b1011 -> slot0=1, slot1=2, slot2=0, slot3=3; next cycle o_count = 28.
- Allocate 4 per cycle for 7 cycles (28 tags), then request mask 4'b1111 -> o_ready = 0, head unchanged; mask 4'b0111 -> o_ready = 1, tags 29,30,31, o_count = 0 afterwards.
- Drain to count 0, free tags {5,9} via mask 4'b0101 -> o_ready stays 0 that cycle for mask 4'b0001; next cycle mask 4'b0011 returns 5, 9.
- Save with alloc mask 4'b0001 (gets tag 1), allocate 8 more tags, free tag 20, then return -> o_busy 1->0, o_count = 31 - 1 + 1 = 31, next allocation returns tag 2.
- i_save and i_return same cycle with a pending alloc -> o_ready = 0, no tags issued, checkpoint unchanged, o_busy = 0.
- With FREELIST_CHECK_EN: from reset, free tag 7 -> o_err = 1 next cycle and stays 1 until i_rst; without macro o_err stays 0.
